// File: rtl/preempt_context_switch.sv
// Reacts to preemption requests: waits for an instruction boundary, saves PC/ACC on a
// small LIFO, forces the reset instruction into the IR, and re-arms the preemption timer.
module preempt_context_switch #(
    parameter int                     DATA_WIDTH  = 16,
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] RESET_INSTR = '0,
    parameter int                     CTX_DEPTH   = 4
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         preemptSignal,
    input  logic                         instrDone,
    input  logic [PC_WIDTH-1:0]          pcIn,
    input  logic [DATA_WIDTH-1:0]        accIn,
    input  logic                         irAck,
    input  logic                         restoreReq,
    output logic                         irOverride,
    output logic [INSTR_WIDTH-1:0]       irOverrideInstr,
    output logic                         startCountSignal,
    output logic                         restoreValid,
    output logic [PC_WIDTH-1:0]          restorePc,
    output logic [DATA_WIDTH-1:0]        restoreAcc,
    output logic [$clog2(CTX_DEPTH):0]   ctxCount,
    output logic                         ctxError,
    output logic                         busy
);

    localparam int AW = $clog2(CTX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(CTX_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_BOUNDARY, INJECT} state_t;

    state_t state, stateNext;

    logic preemptQ;
    logic pendingQ;
    logic pendingNext;
    logic request;
    logic doPush;
    logic doPop;
    logic pushFull;
    logic popEmpty;
    logic rearm;
    logic [AW-1:0] topIdx;

    logic [PC_WIDTH-1:0]   stackPc  [CTX_DEPTH];
    logic [DATA_WIDTH-1:0] stackAcc [CTX_DEPTH];

    assign request         = preemptSignal & ~preemptQ;
    assign topIdx          = ctxCount[AW-1:0] - AW'(1);
    assign irOverrideInstr = RESET_INSTR;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A preempt in IDLE always beats a simultaneous restore request.
    always_comb begin
        stateNext   = state;
        pendingNext = pendingQ;
        doPush      = 1'b0;
        doPop       = 1'b0;
        pushFull    = 1'b0;
        popEmpty    = 1'b0;
        rearm       = 1'b0;
        case (state)
            IDLE: begin
                if (request || pendingQ) begin
                    stateNext   = WAIT_BOUNDARY;
                    pendingNext = 1'b0;
                end else if (restoreReq) begin
                    if (ctxCount != '0) begin
                        doPop = 1'b1;
                    end else begin
                        popEmpty = 1'b1;
                    end
                end
            end
            WAIT_BOUNDARY: begin
                if (request) begin
                    pendingNext = 1'b1;
                end
                if (instrDone) begin
                    if (ctxCount < FULL_COUNT) begin
                        doPush    = 1'b1;
                        stateNext = INJECT;
                    end else begin
                        pushFull  = 1'b1;
                        rearm     = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            INJECT: begin
                if (request) begin
                    pendingNext = 1'b1;
                end
                if (irAck) begin
                    rearm     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            preemptQ         <= 1'b0;
            pendingQ         <= 1'b0;
            ctxCount         <= '0;
            ctxError         <= 1'b0;
            irOverride       <= 1'b0;
            startCountSignal <= 1'b0;
            restoreValid     <= 1'b0;
            busy             <= 1'b0;
            restorePc        <= '0;
            restoreAcc       <= '0;
        end else begin
            preemptQ         <= preemptSignal;
            pendingQ         <= pendingNext;
            ctxError         <= ctxError | pushFull | popEmpty;
            irOverride       <= (stateNext == INJECT);
            busy             <= (stateNext != IDLE);
            startCountSignal <= rearm;
            restoreValid     <= doPop;
            if (doPush) begin
                ctxCount <= ctxCount + CW'(1);
            end else if (doPop) begin
                ctxCount <= ctxCount - CW'(1);
            end
            if (doPop) begin
                restorePc  <= stackPc[topIdx];
                restoreAcc <= stackAcc[topIdx];
            end
        end
    end

    // Stack storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (doPush) begin
            stackPc[ctxCount[AW-1:0]]  <= pcIn;
            stackAcc[ctxCount[AW-1:0]] <= accIn;
        end
    end

endmodule

// File: tb/tb_preempt_context_switch.sv
// Directed plus randomized bench for preempt_context_switch; expected values come
// from a queue-based LIFO model and the documented handshake timing.
module tb_preempt_context_switch;

    localparam int DW    = 16;
    localparam int PW    = 8;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic          clock         = 1'b0;
    logic          resetN        = 1'b0;
    logic          preemptSignal = 1'b0;
    logic          instrDone     = 1'b0;
    logic          irAck         = 1'b0;
    logic          restoreReq    = 1'b0;
    logic [PW-1:0] pcIn          = '0;
    logic [DW-1:0] accIn         = '0;

    logic          irOverride;
    logic [IW-1:0] irOverrideInstr;
    logic          startCountSignal;
    logic          restoreValid;
    logic [PW-1:0] restorePc;
    logic [DW-1:0] restoreAcc;
    logic [2:0]    ctxCount;
    logic          ctxError;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [PW+DW-1:0] model[$];
    logic             modelErr = 1'b0;
    logic [PW-1:0]    lastPc   = '0;
    logic [DW-1:0]    lastAcc  = '0;

    preempt_context_switch #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .INSTR_WIDTH(IW),
        .RESET_INSTR(16'h0000),
        .CTX_DEPTH  (DEPTH)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .preemptSignal   (preemptSignal),
        .instrDone       (instrDone),
        .pcIn            (pcIn),
        .accIn           (accIn),
        .irAck           (irAck),
        .restoreReq      (restoreReq),
        .irOverride      (irOverride),
        .irOverrideInstr (irOverrideInstr),
        .startCountSignal(startCountSignal),
        .restoreValid    (restoreValid),
        .restorePc       (restorePc),
        .restoreAcc      (restoreAcc),
        .ctxCount        (ctxCount),
        .ctxError        (ctxError),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyRequest(input logic withRestore);
        preemptSignal = 1'b1;
        restoreReq    = withRestore;
        tick();
        preemptSignal = 1'b0;
        restoreReq    = 1'b0;
        checkOutput("busyAfterReq", 32'(busy), 1);
        checkOutput("noRestoreOnReq", 32'(restoreValid), 0);
        checkOutput("countOnReq", 32'(ctxCount), 32'(model.size()));
    endtask

    task automatic applyBoundary(input logic [PW-1:0] pc, input logic [DW-1:0] acc,
                                 input int doneDelay, input int ackDelay, input logic retrig);
        pcIn  = pc;
        accIn = acc;
        for (int i = 0; i < doneDelay; i++) begin
            restoreReq = 1'($urandom_range(0, 1));
            tick();
            checkOutput("waitBusy", 32'(busy), 1);
            checkOutput("waitNoOverride", 32'(irOverride), 0);
        end
        restoreReq = 1'b0;
        instrDone  = 1'b1;
        tick();
        instrDone = 1'b0;
        if (model.size() < DEPTH) begin
            model.push_back({pc, acc});
            checkOutput("pushCount", 32'(ctxCount), 32'(model.size()));
            checkOutput("overrideHigh", 32'(irOverride), 1);
            checkOutput("overrideInstr", 32'(irOverrideInstr), 32'h0000);
            checkOutput("noEarlyRearm", 32'(startCountSignal), 0);
            for (int i = 0; i < ackDelay; i++) begin
                restoreReq    = 1'($urandom_range(0, 1));
                preemptSignal = retrig && (i == 1);
                tick();
                checkOutput("overrideHeld", 32'(irOverride), 1);
                checkOutput("noRearmBeforeAck", 32'(startCountSignal), 0);
                checkOutput("restoreIgnored", 32'(restoreValid), 0);
            end
            preemptSignal = 1'b0;
            restoreReq    = 1'b0;
            irAck         = 1'b1;
            tick();
            irAck = 1'b0;
            checkOutput("overrideDropped", 32'(irOverride), 0);
            checkOutput("rearmPulse", 32'(startCountSignal), 1);
            checkOutput("idleAfterAck", 32'(busy), 0);
            checkOutput("countAfterAck", 32'(ctxCount), 32'(model.size()));
        end else begin
            modelErr = 1'b1;
            checkOutput("fullCount", 32'(ctxCount), DEPTH);
            checkOutput("fullError", 32'(ctxError), 1);
            checkOutput("fullNoOverride", 32'(irOverride), 0);
            checkOutput("fullRearm", 32'(startCountSignal), 1);
            checkOutput("fullIdle", 32'(busy), 0);
        end
        tick();
        checkOutput("rearmOnePulse", 32'(startCountSignal), 0);
        checkOutput("errorSticky", 32'(ctxError), 32'(modelErr));
        checkOutput("pendingBusy", 32'(busy), 32'(retrig));
    endtask

    task automatic applyStimulus(input logic [PW-1:0] pc, input logic [DW-1:0] acc,
                                 input int doneDelay, input int ackDelay);
        applyRequest(1'b0);
        applyBoundary(pc, acc, doneDelay, ackDelay, 1'b0);
    endtask

    task automatic applyPop();
        logic [PW+DW-1:0] entry;
        restoreReq = 1'b1;
        tick();
        restoreReq = 1'b0;
        if (model.size() > 0) begin
            entry   = model.pop_back();
            lastPc  = entry[PW+DW-1:DW];
            lastAcc = entry[DW-1:0];
            checkOutput("popValid", 32'(restoreValid), 1);
        end else begin
            modelErr = 1'b1;
            checkOutput("emptyNoValid", 32'(restoreValid), 0);
            checkOutput("emptyError", 32'(ctxError), 1);
        end
        checkOutput("popPc", 32'(restorePc), 32'(lastPc));
        checkOutput("popAcc", 32'(restoreAcc), 32'(lastAcc));
        checkOutput("popCount", 32'(ctxCount), 32'(model.size()));
        tick();
        checkOutput("validOnePulse", 32'(restoreValid), 0);
        checkOutput("popErrorSticky", 32'(ctxError), 32'(modelErr));
    endtask

    initial begin
        repeat (2) tick();
        checkOutput("resetBusy", 32'(busy), 0);
        checkOutput("resetOverride", 32'(irOverride), 0);
        checkOutput("resetCount", 32'(ctxCount), 0);
        checkOutput("resetError", 32'(ctxError), 0);
        checkOutput("resetValid", 32'(restoreValid), 0);
        checkOutput("resetRearm", 32'(startCountSignal), 0);
        checkOutput("resetPc", 32'(restorePc), 0);
        resetN = 1'b1;
        tick();

        // Basic preempt followed by restore and an underflowing restore.
        applyStimulus(8'h12, 16'hBEEF, 1, 0);
        applyPop();
        applyPop();

        // Fill the stack, overflow it, then drain in LIFO order.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(PW'(i), DW'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        applyStimulus(8'h05, 16'h5555, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyPop();
        end

        // New preempt edge while the IR ack is held off.
        applyRequest(1'b0);
        applyBoundary(8'hA1, 16'h1111, 0, 5, 1'b1);
        applyBoundary(8'hA2, 16'h2222, 1, 1, 1'b0);
        checkOutput("pendingPushCount", 32'(ctxCount), 2);

        // Preempt coinciding with a restore request.
        applyPop();
        applyRequest(1'b1);
        applyBoundary(8'hB3, 16'h3333, 0, 1, 1'b0);
        checkOutput("simulCount", 32'(ctxCount), 2);

        // Asynchronous reset while injecting.
        applyRequest(1'b0);
        pcIn      = 8'hC4;
        instrDone = 1'b1;
        tick();
        instrDone = 1'b0;
        checkOutput("injectBeforeReset", 32'(irOverride), 1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("asyncOverride", 32'(irOverride), 0);
        checkOutput("asyncCount", 32'(ctxCount), 0);
        checkOutput("asyncBusy", 32'(busy), 0);
        checkOutput("asyncError", 32'(ctxError), 0);
        model.delete();
        modelErr = 1'b0;
        lastPc   = '0;
        lastAcc  = '0;
        tick();
        resetN = 1'b1;
        tick();
        applyStimulus(8'hD5, 16'h4444, 0, 0);

        // Randomized mix of preempts and restores.
        repeat (60) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(PW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                applyPop();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/preempt_context_switch.md
# preempt_context_switch

Downstream consumer of the preemption timer's `preemptSignal`. It waits for the current instruction to retire, then pushes the running context (PC, ACC) onto a small context stack. It forces the reset instruction into the instruction register through an override handshake and re-arms the timer with a `startCountSignal` pulse. The control unit pops a saved context on request.

## Interface
- `DATA_WIDTH`, 16: accumulator width.
- `PC_WIDTH`, 8: program counter width.
- `INSTR_WIDTH`, 16: instruction register width.
- `RESET_INSTR`, 16'h0000: instruction word injected on preemption.
- `CTX_DEPTH`, 4: context stack entries; power of two, ≥2.
- `clock`  in  1  sole clock; all state updates on posedge.
- `resetN`  in  1  asynchronous, active-low reset.
- `preemptSignal`  in  1  from preemption timer; rising edge = preempt request.
- `instrDone`  in  1  control unit: current instruction retires this cycle.
- `pcIn`  in  PC_WIDTH  current PC.
- `accIn`  in  DATA_WIDTH  current ACC.
- `irAck`  in  1  IR has loaded `irOverrideInstr`.
- `restoreReq`  in  1  control unit requests pop of the newest context.
- `irOverride`  out  1  IR must load `irOverrideInstr`.
- `irOverrideInstr`  out  INSTR_WIDTH  constant RESET_INSTR.
- `startCountSignal`  out  1  one-cycle pulse that re-arms the timer.
- `restoreValid`  out  1  one-cycle pulse; `restorePc`/`restoreAcc` are valid.
- `restorePc`  out  PC_WIDTH  popped PC.
- `restoreAcc`  out  DATA_WIDTH  popped ACC.
- `ctxCount`  out  clog2(CTX_DEPTH)+1  stack occupancy.
- `ctxError`  out  1  sticky: push on full or pop on empty.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Edge detect: register `preemptSignal` into `preemptQ`. Request = `preemptSignal & ~preemptQ`. A request arriving outside IDLE sets a single `pendingQ` bit. Further requests while `pendingQ=1` are merged. `pendingQ` is consumed on the next return to IDLE.
- FSM states: IDLE, WAIT_BOUNDARY, INJECT.
  - IDLE: a request (or `pendingQ`) moves to WAIT_BOUNDARY. Otherwise, `restoreReq=1` triggers a pop. If a request and `restoreReq` coincide, the preempt wins and `restoreReq` is ignored. The control unit must re-assert it.
  - WAIT_BOUNDARY: on an edge with `instrDone=1`:
    - If `ctxCount<CTX_DEPTH`: push {`pcIn`,`accIn`}, `ctxCount`+1, go to INJECT.
    - If full: no push, set `ctxError`, pulse `startCountSignal`, go to IDLE.
  - INJECT: `irOverride=1`. On an edge with `irAck=1`: go to IDLE and pulse `startCountSignal`.
- Pop from IDLE:
  - If `ctxCount>0`: `ctxCount`-1; `restorePc`/`restoreAcc` load the top entry; `restoreValid=1` for one cycle.
  - If `ctxCount=0`: set `ctxError`, no pulse, outputs unchanged.
- Stack is LIFO, top index = `ctxCount`-1. `ctxCount` saturates at 0 and at CTX_DEPTH, never wraps.
- `ctxError` clears only on reset.
- `restoreReq` is ignored in WAIT_BOUNDARY and INJECT, with no error.

## Timing
- Reset (`resetN=0`, async, any state):
  - state=IDLE; `preemptQ`, `pendingQ`, `ctxCount`, `ctxError` = 0.
  - `irOverride`, `startCountSignal`, `restoreValid`, `busy` = 0.
  - `restorePc`/`restoreAcc` = 0; stack contents don't-care.
  - An in-flight injection is abandoned.
- All outputs are registered except `irOverrideInstr`, which is constant.
- Request sampled at edge T: `busy=1` from T+1.
- Push at the edge where WAIT_BOUNDARY sees `instrDone=1`. If `instrDone=1` already at T+1, the push occurs at edge T+1 and `irOverride=1` from T+2.
- `irOverride` falls, and `startCountSignal` is high, during the cycle after the `irAck` edge. Minimum request-to-re-arm: 3 edges after the request edge.
- Pop: `restoreReq` sampled at edge T gives `restoreValid=1` and data during T+1, and `ctxCount` updated in T+1.
- Pending preempt: WAIT_BOUNDARY is entered on the edge after returning to IDLE.

## Test plan
- Basic preempt: reset, `pcIn`=8'h12, `accIn`=16'hBEEF. Raise `preemptSignal`, `instrDone`=1 two cycles later, `irAck` one cycle after `irOverride`.
  - Expect: `ctxCount`=1, `irOverride` high until the ack, `irOverrideInstr`=16'h0000, a single `startCountSignal` pulse.
- Restore: after the above, pulse `restoreReq`.
  - Expect: next cycle `restoreValid`=1, `restorePc`=8'h12, `restoreAcc`=16'hBEEF, `ctxCount`=0. A second `restoreReq` sets `ctxError` with no `restoreValid`.
- Full stack: 4 preempts with PC 1..4, then a 5th.
  - Expect: 5th sets `ctxError`, `ctxCount` stays 4, no `irOverride`, `startCountSignal` still pulses.
  - Then 4 pops return PC 4,3,2,1.
- Preempt during INJECT, with `irAck` held low 5 cycles and a new `preemptSignal` rising edge.
  - Expect: after the ack, IDLE for one cycle, then WAIT_BOUNDARY. Second push gives `ctxCount`=2.
- Simultaneous preempt and `restoreReq` in IDLE with `ctxCount`=1.
  - Expect: preempt taken, no `restoreValid`, `ctxCount` becomes 2 after the boundary.
- Reset asserted in INJECT.
  - Expect: `irOverride`=0 and `ctxCount`=0 immediately (async). After release, state is IDLE and a new preempt works normally.
